id_issue_ctrl: RTL
==================

Name: id_issue_ctrl

Overview:
- Issue controller and scoreboard for the decode stage. Sits between the decoder outputs and the execute stage.
- Tracks in-flight destination-register writes and detects RAW hazards on rs1/rs2. Stalls decode (id_ready low) until operands are safe, then pulses id_issue.
- Also provides a drain/fence sequencer and a stall-cycle performance counter.

Parameters:
- XREG_ADDRWIDTH, 5, register-address width (32 architectural registers).
- ALU_LAT, 3, cycles from issue until a non-load result is readable from the register file.
- LOAD_LAT, 4, the same latency for loads (opcode 7'b0000011).
- CNT_W, 3, scoreboard counter width. Legal only if 1 <= ALU_LAT <= LOAD_LAT <= 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decoder holds a valid instruction.
- id_opcode  in  7  decoded opcode.
- id_rs1_en  in  1  rs1 is read.
- id_rs1  in  XREG_ADDRWIDTH  rs1 address.
- id_rs2_en  in  1  rs2 is read.
- id_rs2  in  XREG_ADDRWIDTH  rs2 address.
- id_rd_en  in  1  rd is written.
- id_rd  in  XREG_ADDRWIDTH  rd address.
- ex_stall  in  1  downstream back-pressure; freezes the pipeline.
- flush  in  1  taken branch/jump from EX; kills the decode-stage instruction.
- drain_req  in  1  request to wait until all in-flight writes retire.
- id_ready  out  1  decode instruction may issue this cycle.
- id_issue  out  1  issue pulse (id_valid & id_ready).
- hazard_rs1  out  1  rs1 RAW hazard present.
- hazard_rs2  out  1  rs2 RAW hazard present.
- fwd_rs1  out  1  rs1 must come from the bypass network (ID_FWD_EN only, else 0).
- fwd_rs2  out  1  rs2 must come from the bypass network (ID_FWD_EN only, else 0).
- drain_done  out  1  drain complete.
- sb_busy  out  32  bit r = counter of register r is nonzero.
- stall_cycles  out  32  saturating count of stalled cycles.

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low.
- Reset: all counters cnt[r]=0, all ld_pend[r]=0, FSM=RUN, stall_cycles=0. Consequently sb_busy=0, drain_done=0, hazard_*=0, fwd_*=0. id_ready follows from inputs (combinational).
- Scoreboard: per register r, cnt[r] (CNT_W bits) and ld_pend[r] (1 bit).
  - When ex_stall=0, each nonzero cnt decrements by 1 per cycle.
  - When ex_stall=1, all counters and flags hold.
  - When cnt reaches 0, ld_pend clears.
  - On an issue edge with id_rd_en=1 and id_rd!=0: cnt[id_rd] <= (load ? LOAD_LAT : ALU_LAT) and ld_pend[id_rd] <= load. This overrides any decrement of the same entry that cycle; a newer write always replaces an older one.
  - Register x0 is never marked busy.
- Hazard terms (combinational):
  - hazard_rsN = id_valid & id_rsN_en & (id_rsN!=0) & H(id_rsN).
  - Without ID_FWD_EN: H(r) = cnt[r]!=0.
- Issue rule:
  - id_ready = ~hazard_rs1 & ~hazard_rs2 & ~ex_stall & ~flush & (FSM==RUN).
  - id_issue = id_valid & id_ready.
  - No latency beyond combinational.
  - flush overrides everything: no issue and no scoreboard update from the decode instruction. Entries of already-issued instructions are kept.
- Stall counter: increments when id_valid & ~id_ready & ~flush; saturates at 32'hFFFFFFFF.
- Drain FSM, states RUN, DRAIN, DONE:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> DONE when sb_busy==0. This may happen in the same cycle as entry if the scoreboard is already empty; in that case DONE is reached in the next cycle.
  - DONE: drain_done=1; DONE -> RUN when drain_req=0.
  - drain_req dropped during DRAIN -> RUN.
  - Issue is blocked outside RUN.
  - drain_req and an issue in the same RUN cycle: the issue proceeds and its entry is drained.
- Reset asserted mid-operation clears all state on that edge; pending hazards vanish.

Optional Feature:
- Macro ID_FWD_EN, defined: bypass network present.
  - H(r) = ld_pend[r] & (cnt[r]==LOAD_LAT). This produces exactly one load-use bubble; ALU results never stall.
  - fwd_rsN = id_rsN_en & (id_rsN!=0) & (cnt[id_rsN]!=0) & ~hazard_rsN.
- Macro not defined: full-interlock behaviour as specified above; fwd_* tied to 0.

Test Plan:
- Reset with rst_n=0 for 2 cycles while id_valid=1, no hazard -> sb_busy=0, stall_cycles=0, drain_done=0; id_issue=1 once rst_n=1.
- No FWD, ALU_LAT=3: issue rd=x5 in cycle 0; dependent rs1=x5 valid from cycle 1 -> hazard_rs1=1 in cycles 1-3, id_issue in cycle 4, stall_cycles=3.
- ID_FWD_EN, LOAD_LAT=4: load rd=x6 in cycle 0; dependent rs2=x6 -> 1 stall cycle, issue in cycle 2 with fwd_rs2=1. An ALU-producer dependent issues in cycle 1 with fwd_rs1=1.
- Write to x0, then read x0 -> sb_busy[0]=0, no hazard. rd=x7 re-issued while cnt[x7]=1 -> cnt[x7]=ALU_LAT afterwards.
- ex_stall=1 for 2 cycles with cnt[x5]=2 -> count holds at 2, then decrements once ex_stall drops. A flush cycle with id_valid=1 -> id_issue=0 and no scoreboard update.
- drain_req=1 with cnt[x3]=3 -> drain_done=1 after 3-4 cycles, issue blocked meanwhile; drain_req=0 -> RUN next cycle, issue resumes.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// rtl/id_issue_ctrl.sv - decode-stage issue controller: RAW scoreboard, drain sequencer, stall counter
// Optional bypass network support is enabled by defining ID_FWD_EN.
module id_issue_ctrl #(
  parameter int XREG_ADDRWIDTH = 5,
  parameter int ALU_LAT        = 3,
  parameter int LOAD_LAT       = 4,
  parameter int CNT_W          = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [6:0]                id_opcode,
  input  logic                      id_rs1_en,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs1,
  input  logic                      id_rs2_en,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs2,
  input  logic                      id_rd_en,
  input  logic [XREG_ADDRWIDTH-1:0] id_rd,
  input  logic                      ex_stall,
  input  logic                      flush,
  input  logic                      drain_req,
  output logic                      id_ready,
  output logic                      id_issue,
  output logic                      hazard_rs1,
  output logic                      hazard_rs2,
  output logic                      fwd_rs1,
  output logic                      fwd_rs2,
  output logic                      drain_done,
  output logic [31:0]               sb_busy,
  output logic [31:0]               stall_cycles
);

  localparam int NREG = 1 << XREG_ADDRWIDTH;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  ld_pend_q, ld_pend_d;
  logic [31:0]      stall_q, stall_d;

  logic is_load;
  logic busy_rs1, busy_rs2;
  logic h_rs1, h_rs2;

  assign is_load = (id_opcode == 7'b0000011);

  always_comb begin
    busy_rs1 = (cnt_q[id_rs1] != '0);
    busy_rs2 = (cnt_q[id_rs2] != '0);
`ifdef ID_FWD_EN
    // Only a load in its first cycle cannot be bypassed: one load-use bubble.
    h_rs1 = ld_pend_q[id_rs1] && (cnt_q[id_rs1] == CNT_W'(LOAD_LAT));
    h_rs2 = ld_pend_q[id_rs2] && (cnt_q[id_rs2] == CNT_W'(LOAD_LAT));
`else
    h_rs1 = busy_rs1;
    h_rs2 = busy_rs2;
`endif
    hazard_rs1 = id_valid && id_rs1_en && (id_rs1 != '0) && h_rs1;
    hazard_rs2 = id_valid && id_rs2_en && (id_rs2 != '0) && h_rs2;
    id_ready   = !hazard_rs1 && !hazard_rs2 && !ex_stall && !flush && (state_q == ST_RUN);
    id_issue   = id_valid && id_ready;
`ifdef ID_FWD_EN
    fwd_rs1 = id_rs1_en && (id_rs1 != '0) && busy_rs1 && !hazard_rs1;
    fwd_rs2 = id_rs2_en && (id_rs2 != '0) && busy_rs2 && !hazard_rs2;
`else
    fwd_rs1 = 1'b0;
    fwd_rs2 = 1'b0;
`endif
  end

  always_comb begin
    sb_busy = '0;
    for (int r = 0; r < 32; r++) begin
      if (r < NREG) sb_busy[r] = (cnt_q[r] != '0);
    end
  end

  // Scoreboard: age every entry, then let a new issue overwrite its rd entry.
  always_comb begin
    ld_pend_d = ld_pend_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!ex_stall && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
        if (cnt_q[r] == CNT_W'(1)) ld_pend_d[r] = 1'b0;
      end
    end
    if (id_issue && id_rd_en && (id_rd != '0)) begin
      cnt_d[id_rd]     = is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
      ld_pend_d[id_rd] = is_load;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (id_valid && !id_ready && !flush && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)          state_d = ST_RUN;
        else if (sb_busy == '0)  state_d = ST_DONE;
      end
      ST_DONE:  if (!drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign drain_done   = (state_q == ST_DONE);
  assign stall_cycles = stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      ld_pend_q <= '0;
      stall_q   <= '0;
      state_q   <= ST_RUN;
    end else begin
      cnt_q     <= cnt_d;
      ld_pend_q <= ld_pend_d;
      stall_q   <= stall_d;
      state_q   <= state_d;
    end
  end

endmodule
